// File: rtl/temporal_encoder.sv
// Race-logic temporal encoder: per-channel binary values become spike lines timed within a gamma cycle.
// Vectors enter a shadow buffer over valid/ready and are promoted to the active set at each slot-0 edge.
module temporal_encoder #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned NUM_INPUTS        = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned PULSE_MODE        = 0,
    parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                        aclk,
    input  logic                        grst,
    input  logic                        en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_INPUTS*VAL_W-1:0] in_data,
    output logic [NUM_INPUTS-1:0]       y,
    output logic                        gamma_start,
    output logic                        underrun
);

    localparam int unsigned SLOT_W = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int unsigned CMP_W  = VAL_W + 1;
    localparam int unsigned DATA_W = NUM_INPUTS * VAL_W;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [CMP_W-1:0]  GAMMA_C   = CMP_W'(GAMMA_CYCLE_WIDTH);
    localparam logic [CMP_W-1:0]  PULSE_C   = CMP_W'(PULSE_WIDTH);
    localparam logic [VAL_W-1:0]  NEVER_VAL = VAL_W'(GAMMA_CYCLE_WIDTH);
    localparam logic [DATA_W-1:0] ALL_NEVER = {NUM_INPUTS{NEVER_VAL}};

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  run_q, run_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_W-1:0]     active_q, active_d;
    logic [NUM_INPUTS-1:0] y_q, y_d;
    logic                  gamma_start_q, gamma_start_d;
    logic                  underrun_q, underrun_d;
    logic                  handshake;
    logic                  begin_slot0;

    // Spike rule for one channel at slot s; widened compare keeps v+PULSE_WIDTH from wrapping.
    function automatic logic spike(input logic [VAL_W-1:0] v, input logic [SLOT_W-1:0] s);
        logic [CMP_W-1:0] v_ext;
        logic [CMP_W-1:0] s_ext;
        logic             hit;
        v_ext = CMP_W'(v);
        s_ext = CMP_W'(s);
        hit   = (v_ext < GAMMA_C) && (s_ext >= v_ext);
        if (PULSE_MODE != 0) begin
            hit = hit && (s_ext < (v_ext + PULSE_C));
        end
        return hit;
    endfunction

    always_comb begin
        slot_d        = slot_q;
        run_d         = run_q;
        shadow_d      = shadow_q;
        in_ready_d    = in_ready_q;
        active_d      = active_q;
        y_d           = '0;
        gamma_start_d = 1'b0;
        underrun_d    = 1'b0;
        begin_slot0   = 1'b0;
        handshake     = in_valid && in_ready_q;

        if (en) begin
            run_d       = 1'b1;
            begin_slot0 = !run_q || (slot_q == LAST_SLOT);
            slot_d      = begin_slot0 ? '0 : slot_q + SLOT_W'(1);
        end else begin
            run_d  = 1'b0;
            slot_d = '0;
        end

        // Promotion looks at the pre-edge shadow; a same-edge handshake only refills the shadow.
        if (begin_slot0) begin
            gamma_start_d = 1'b1;
            if (!in_ready_q) begin
                active_d   = shadow_q;
                in_ready_d = 1'b1;
            end else begin
                active_d   = ALL_NEVER;
                underrun_d = 1'b1;
            end
        end

        if (handshake) begin
            shadow_d   = in_data;
            in_ready_d = 1'b0;
        end

        if (en) begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                y_d[i] = spike(active_d[i*VAL_W +: VAL_W], slot_d);
            end
        end
    end

    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            slot_q        <= '0;
            run_q         <= 1'b0;
            shadow_q      <= '0;
            in_ready_q    <= 1'b1;
            active_q      <= ALL_NEVER;
            y_q           <= '0;
            gamma_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            run_q         <= run_d;
            shadow_q      <= shadow_d;
            in_ready_q    <= in_ready_d;
            active_q      <= active_d;
            y_q           <= y_d;
            gamma_start_q <= gamma_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign y           = y_q;
    assign gamma_start = gamma_start_q;
    assign underrun    = underrun_q;

endmodule
